// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution host and its memories.
//   state_t          : host FSM states
//   CSEL_L0, CSEL_L1 : layer bank select codes
//   DATA_W, ADDR_W   : data word width (signed Q4.16) and address width
package conv_pkg;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 12;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        LOAD,
        OFFER,
        RUN,
        DUMP,
        FIN
    } state_t;

    // True for the two bank codes that address a real layer memory.
    function automatic logic csel_known(input logic [2:0] csel);
        return (csel == CSEL_L0) || (csel == CSEL_L1);
    endfunction

endpackage

// File: rtl/layer_ram.sv
// layer_ram: single-write, multi-read memory with synchronous write and
// asynchronous (zero-latency) reads. Contents have no reset so they survive
// a host reset.
//   clk    : write clock
//   we     : write enable, wdata lands at waddr on the rising edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : one address per read port (packed, port 0 in the low bits)
//   rdata  : one data word per read port, combinational from raddr
module layer_ram #(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 20,
    parameter int RD_PORTS = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [AW-1:0]                      waddr,
    input  logic [WIDTH-1:0]                   wdata,
    input  logic [RD_PORTS-1:0][AW-1:0]        raddr,
    output logic [RD_PORTS-1:0][WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Reads see the contents before any write in the same cycle.
    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            assign rdata[gi] = mem_q[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/conv_host.sv
// conv_host: host side of a convolution accelerator. Loads an image, offers
// it to the accelerator, serves image and layer-bank accesses while the
// accelerator runs, then streams the pooled layer (L1) out.
//   clk, reset           : clock, synchronous active-low reset
//   ld_valid/ld_data/ld_ready : image load stream
//   ready, busy          : image-resident request / accelerator working
//   iaddr, idata         : image read port (combinational)
//   cwr/caddr_wr/cdata_wr: layer write port
//   crd/caddr_rd/cdata_rd: layer read port (combinational)
//   csel                 : bank select, L0 or L1
//   dout_valid/dout_data/dout_ready : L1 dump stream
//   done                 : dump complete
//   err                  : sticky protocol error
module conv_host
    import conv_pkg::*;
#(
    parameter int IMG_DEPTH = 4096,
    parameter int L1_DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic [2:0]        csel,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout_data,
    input  logic              dout_ready,
    output logic              done,
    output logic              err
);

    localparam int L1_AW = $clog2(L1_DEPTH);
    localparam logic [ADDR_W-1:0] LD_LAST   = ADDR_W'(IMG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] L1_LIMIT  = ADDR_W'(L1_DEPTH);
    localparam logic [L1_AW-1:0]  DUMP_LAST = L1_AW'(L1_DEPTH - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [L1_AW-1:0]   dump_cnt_q, dump_cnt_d;
    logic               busy_q;
    logic               err_q, err_d;
    logic               ld_ready_q, ld_ready_d;
    logic               ready_q, ready_d;
    logic               dout_valid_q, dout_valid_d;
    logic               done_q, done_d;

    logic               img_we, l0_we, l1_we, wr_bad, access_idle;
    logic [DATA_W-1:0]  l0_rd;
    logic [1:0][DATA_W-1:0] l1_rd;

    // Image load, L0 and L1 writes. An L1 write beyond the bank is dropped
    // rather than aliased onto a lower address.
    assign img_we = (state_q == LOAD) && ld_valid;
    assign l0_we  = cwr && (csel == CSEL_L0);
    assign l1_we  = cwr && (csel == CSEL_L1) && (caddr_wr < L1_LIMIT);
    assign wr_bad = cwr && (!csel_known(csel) ||
                            ((csel == CSEL_L1) && (caddr_wr >= L1_LIMIT)));
    assign access_idle = (cwr || crd) && (state_q != RUN);

    layer_ram #(.DEPTH(1 << ADDR_W), .WIDTH(DATA_W), .RD_PORTS(1)) u_img (
        .clk   (clk),
        .we    (img_we),
        .waddr (ld_cnt_q),
        .wdata (ld_data),
        .raddr (iaddr),
        .rdata (idata)
    );

    layer_ram #(.DEPTH(1 << ADDR_W), .WIDTH(DATA_W), .RD_PORTS(1)) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (caddr_rd),
        .rdata (l0_rd)
    );

    // L1 has a second read port so the dump stream never competes with
    // host reads.
    layer_ram #(.DEPTH(L1_DEPTH), .WIDTH(DATA_W), .RD_PORTS(2)) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr ({dump_cnt_q, caddr_rd[L1_AW-1:0]}),
        .rdata (l1_rd)
    );

    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (csel == CSEL_L0) begin
                cdata_rd = l0_rd;
            end else if (csel == CSEL_L1) begin
                cdata_rd = l1_rd[0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        dump_cnt_d = dump_cnt_q;
        err_d      = err_q || wr_bad || access_idle;
        case (state_q)
            LOAD: begin
                if (ld_valid) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == LD_LAST) begin
                        state_d = OFFER;
                    end
                end
            end
            OFFER: begin
                if (busy) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Falling edge of busy: accelerator has finished.
                if (busy_q && !busy) begin
                    state_d    = DUMP;
                    dump_cnt_d = '0;
                end
            end
            DUMP: begin
                if (dout_ready) begin
                    dump_cnt_d = dump_cnt_q + 1'b1;
                    if (dump_cnt_q == DUMP_LAST) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                if (ld_valid) begin
                    state_d  = LOAD;
                    ld_cnt_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase
        // Outputs are registered from the next state so they change exactly
        // on the transition edge.
        ld_ready_d   = (state_d == LOAD);
        ready_d      = (state_d == OFFER);
        dout_valid_d = (state_d == DUMP);
        done_d       = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= LOAD;
            ld_cnt_q     <= '0;
            dump_cnt_q   <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            ld_ready_q   <= 1'b1;
            ready_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            dump_cnt_q   <= dump_cnt_d;
            busy_q       <= busy;
            err_q        <= err_d;
            ld_ready_q   <= ld_ready_d;
            ready_q      <= ready_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign ready      = ready_q;
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_valid_q ? l1_rd[1] : '0;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_conv_host.sv
// tb_conv_host: directed bench for conv_host. Dump words are checked by a
// scoreboard monitor; other responses are checked inline against
// hand-computed values.
module tb_conv_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [19:0] ld_data;
    logic        ld_ready;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        dout_valid;
    logic [19:0] dout_data;
    logic        dout_ready;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int rx_count = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    conv_host dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ready      (ready),
        .busy       (busy),
        .iaddr      (iaddr),
        .idata      (idata),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .csel       (csel),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_ready (dout_ready),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge, between drive points.
    logic        prev_hold = 1'b0;
    logic [19:0] prev_data = '0;
    always @(negedge clk) begin
        if (prev_hold && dout_valid) begin
            chk("dump_hold", {12'h0, dout_data}, {12'h0, prev_data});
        end
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("dump_extra", 32'd1, 32'd0);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                $display("dump word %0d: %h (expected %h)", rx_count, dout_data, e);
                chk("dump_word", {12'h0, dout_data}, {12'h0, e});
            end
            rx_count++;
        end
        prev_hold = dout_valid && !dout_ready;
        prev_data = dout_data;
    end

    task automatic load_image(input logic [19:0] base);
        for (int i = 0; i < 4096; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + 20'(i);
            tick();
            if (i == 4094) chk("ready_before_last", {31'h0, ready}, 32'd0);
            if (i == 4095) chk("ready_after_last", {31'h0, ready}, 32'd1);
        end
        ld_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; ld_valid = 1'b0; ld_data = '0; busy = 1'b0; iaddr = '0;
        cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
        csel = 3'b001; dout_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_ld_ready",   {31'h0, ld_ready}, 32'd1);
        chk("rst_ready",      {31'h0, ready}, 32'd0);
        chk("rst_dout_valid", {31'h0, dout_valid}, 32'd0);
        chk("rst_dout_data",  {12'h0, dout_data}, 32'd0);
        chk("rst_done",       {31'h0, done}, 32'd0);
        chk("rst_err",        {31'h0, err}, 32'd0);

        // Image load, value = index
        load_image(20'h0);
        iaddr = 12'h0A5; #1;
        chk("idata_0a5", {12'h0, idata}, 32'h000A5);
        iaddr = 12'hFFF; #1;
        chk("idata_fff", {12'h0, idata}, 32'h00FFF);

        // OFFER holds ready while busy stays low
        for (int i = 0; i < 20; i++) tick();
        chk("ready_held", {31'h0, ready}, 32'd1);
        busy = 1'b1;
        tick();
        chk("ready_drop", {31'h0, ready}, 32'd0);

        // L0 write then read
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd100; cdata_wr = 20'h12345;
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd100; #1;
        chk("l0_rd_100", {12'h0, cdata_rd}, 32'h12345);
        crd = 1'b0; #1;
        chk("rd_idle_zero", {12'h0, cdata_rd}, 32'h0);

        // Same-cycle write/read on L1[7]
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd7; cdata_wr = 20'h00001;
        tick();
        cdata_wr = 20'h00002; crd = 1'b1; caddr_rd = 12'd7; #1;
        chk("l1_rw_old", {12'h0, cdata_rd}, 32'h00001);
        tick();
        cwr = 1'b0; #1;
        chk("l1_rw_new", {12'h0, cdata_rd}, 32'h00002);
        crd = 1'b0;

        // Fill L1 with index values; expected dump is that sequence
        for (int i = 0; i < 1024; i++) begin
            cwr = 1'b1; csel = 3'b011; caddr_wr = 12'(i); cdata_wr = 20'(i);
            tick();
            exp_q.push_back(20'(i));
        end
        cwr = 1'b0;
        chk("err_clean", {31'h0, err}, 32'd0);

        // Out-of-range L1 write must not alias onto L1[0]
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd1024; cdata_wr = 20'hFFFFF;
        tick();
        cwr = 1'b0;
        chk("err_l1_range", {31'h0, err}, 32'd1);
        crd = 1'b1; csel = 3'b011; caddr_rd = 12'd0; #1;
        chk("l1_0_intact", {12'h0, cdata_rd}, 32'h0);
        caddr_rd = 12'd1023; #1;
        chk("l1_1023", {12'h0, cdata_rd}, 32'd1023);
        crd = 1'b0;

        // Bad bank select write changes nothing
        cwr = 1'b1; csel = 3'b010; caddr_wr = 12'd100; cdata_wr = 20'hBAD00;
        tick();
        cwr = 1'b0; crd = 1'b1; csel = 3'b001; caddr_rd = 12'd100; #1;
        chk("l0_100_intact", {12'h0, cdata_rd}, 32'h12345);
        csel = 3'b011; #1;
        chk("l1_100_intact", {12'h0, cdata_rd}, 32'd100);
        crd = 1'b0;

        // Busy falls: dump with dout_ready toggling every other cycle
        busy = 1'b0;
        tick();
        chk("dump_start_valid", {31'h0, dout_valid}, 32'd1);
        chk("dump_start_data", {12'h0, dout_data}, 32'h0);
        begin
            int c;
            for (c = 0; c < 5000; c++) begin
                if (done) break;
                dout_ready = ~dout_ready;
                tick();
            end
            chk("dump_timeout", {31'h0, done}, 32'd1);
        end
        dout_ready = 1'b0;
        chk("dump_count", rx_count, 32'd1024);
        chk("dump_queue_empty", exp_q.size(), 32'd0);
        chk("fin_dout_valid", {31'h0, dout_valid}, 32'd0);
        chk("fin_ld_ready", {31'h0, ld_ready}, 32'd0);

        // FIN -> LOAD; the word offered in that cycle is not stored
        ld_valid = 1'b1; ld_data = 20'hBEEF0;
        tick();
        ld_valid = 1'b0;
        chk("fin_done_clear", {31'h0, done}, 32'd0);
        chk("fin_to_load", {31'h0, ld_ready}, 32'd1);
        iaddr = 12'h000; #1;
        chk("img0_intact", {12'h0, idata}, 32'h0);

        // Reset clears err, memories retained; access outside RUN sets err
        do_reset();
        chk("rst2_err", {31'h0, err}, 32'd0);
        crd = 1'b1; csel = 3'b001; caddr_rd = 12'd100; #1;
        chk("l0_retained", {12'h0, cdata_rd}, 32'h12345);
        tick();
        crd = 1'b0;
        chk("err_outside_run", {31'h0, err}, 32'd1);
        do_reset();
        chk("rst3_err", {31'h0, err}, 32'd0);

        // Second load with offset values, then bad bank write in RUN
        load_image(20'h10000);
        iaddr = 12'h0A5; #1;
        chk("idata2_0a5", {12'h0, idata}, 32'h100A5);
        busy = 1'b1;
        tick();
        chk("ready2_drop", {31'h0, ready}, 32'd0);
        chk("err_run_clean", {31'h0, err}, 32'd0);
        cwr = 1'b1; csel = 3'b010; caddr_wr = 12'd100; cdata_wr = 20'hBAD11;
        tick();
        cwr = 1'b0;
        chk("err_bad_csel", {31'h0, err}, 32'd1);
        crd = 1'b1; csel = 3'b001; caddr_rd = 12'd100; #1;
        chk("l0_100_intact2", {12'h0, cdata_rd}, 32'h12345);
        crd = 1'b0;

        // Enter DUMP, stall, then reset mid-dump
        busy = 1'b0;
        tick();
        chk("dump2_valid", {31'h0, dout_valid}, 32'd1);
        tick();
        tick();
        do_reset();
        chk("abort_dout_valid", {31'h0, dout_valid}, 32'd0);
        chk("abort_ld_ready", {31'h0, ld_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_host.md
CONV_HOST -- requirements
Module: conv_host

Interface
REQ-001 Parameter IMG_DEPTH, default 4096, number of image words loaded before ready.
REQ-002 Parameter L1_DEPTH, default 1024, pooled-layer depth streamed out in the dump.
REQ-003 clk  input  1  sole clock, all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 ld_valid  input  1  image load word valid.
REQ-006 ld_data  input  20  image load word, signed Q4.16.
REQ-007 ld_ready  output  1  load word accepted when ld_valid && ld_ready.
REQ-008 ready  output  1  image resident, request to accelerator.
REQ-009 busy  input  1  accelerator working.
REQ-010 iaddr  input  12  image read address.
REQ-011 idata  output  20  image word at iaddr.
REQ-012 cwr  input  1  layer write strobe.
REQ-013 caddr_wr  input  12  layer write address.
REQ-014 cdata_wr  input  20  layer write data.
REQ-015 crd  input  1  layer read strobe.
REQ-016 caddr_rd  input  12  layer read address.
REQ-017 cdata_rd  output  20  layer read data.
REQ-018 csel  input  3  bank select: 3'b001 = L0 (4096 words), 3'b011 = L1 (1024 words).
REQ-019 dout_valid  output  1  dump word valid.
REQ-020 dout_data  output  20  dump word (L1 contents).
REQ-021 dout_ready  input  1  dump word consumed when dout_valid && dout_ready.
REQ-022 done  output  1  dump complete.
REQ-023 err  output  1  sticky protocol-error flag.

Function
REQ-024 FSM states LOAD, OFFER, RUN, DUMP, FIN; reset state LOAD.
REQ-025 LOAD: ld_ready=1; each accepted word written to image RAM at load counter, counter +1; counter reaching IMG_DEPTH-1 on an accepted word -> OFFER.
REQ-026 OFFER: ready=1, held until busy sampled 1, then ready=0 next cycle and -> RUN.
REQ-027 RUN: busy sampled 0 after being 1 (falling edge, registered busy_q) -> DUMP; dump counter cleared.
REQ-028 idata = image[iaddr] combinationally, valid in every state, zero latency.
REQ-029 cdata_rd = bank(csel)[caddr_rd] combinationally when crd=1; 0 when crd=0; L1 read uses caddr_rd[9:0].
REQ-030 Write on rising edge when cwr=1: csel=001 -> L0[caddr_wr]; csel=011 -> L1[caddr_wr[9:0]].
REQ-031 Write with csel not in {001,011}, or csel=011 with caddr_wr>1023: discarded, err set.
REQ-032 cwr && crd same cycle, same bank and address: cdata_rd returns pre-write contents; write lands at the edge.
REQ-033 cwr or crd asserted outside RUN: access performed, err set.
REQ-034 DUMP: dout_data = L1[dump counter], dout_valid=1; counter +1 per handshake; dout_data/dout_valid stable while dout_ready=0.
REQ-035 Handshake on dump counter = L1_DEPTH-1 -> FIN, dout_valid=0 same edge.
REQ-036 FIN: done=1; ld_valid=1 -> LOAD, load counter cleared, done=0 next cycle (word in that cycle not accepted).
REQ-037 Memory contents unchanged by state transitions; only writes alter them.

Reset
REQ-038 reset=0 at a clock edge: state LOAD, load/dump counters 0, busy_q 0, err 0.
REQ-039 Outputs during/after reset: ld_ready=1, ready=0, dout_valid=0, dout_data=0, done=0; idata/cdata_rd follow REQ-028/029.
REQ-040 Reset mid-operation (any state) aborts it, RAM contents retained, not cleared.

Structure
REQ-041 Shared package conv_pkg holds state enum, bank select constants CSEL_L0=3'b001 / CSEL_L1=3'b011, data width 20, address width 12.
REQ-042 One sub-module layer_ram (parameters DEPTH, WIDTH; sync write, async read), instantiated three times: image, L0, L1.

Verification
REQ-043 Load 4096 words value=index -> ready=1 cycle after last accept; iaddr=12'h0A5 -> idata=20'h000A5 same cycle.
REQ-044 OFFER, busy=1 at cycle t -> ready=0 at t+1; ready stays 1 indefinitely if busy held 0.
REQ-045 cwr=1, csel=001, caddr_wr=100, cdata_wr=20'h12345; next cycle crd=1, caddr_rd=100 -> cdata_rd=20'h12345; crd=0 -> 0.
REQ-046 Same-cycle cwr/crd, L1 addr 7 holding 20'h00001, write 20'h00002 -> cdata_rd=20'h00001 that cycle, 20'h00002 next.
REQ-047 csel=3'b010 write, or L1 write caddr_wr=1024 -> no memory change, err=1 until reset.
REQ-048 busy 1->0, L1[i]=i, dout_ready toggling every other cycle -> 1024 words 0..1023 in order, none lost or duplicated, done=1 after last.
